// File: rtl/dataflow_deadlock_monitor.sv
// Per-process deadlock monitor for a dataflow region: flags a process whose owned AXIS
// channels stall while its children (or itself) report blocked, with hold-off and reporting.
module dataflow_deadlock_monitor #(
  parameter int                NUM_AXIS    = 12,
  parameter int                NUM_IDLE    = 21,
  parameter int                NUM_INST    = 16,
  parameter int                NUM_SUB     = 4,
  parameter logic [NUM_AXIS-1:0] AXIS_MASK = 12'hF00,
  parameter logic [NUM_SUB-1:0]  SUB_MASK  = 4'h1,
  parameter int                SELF_CHECK  = 0,
  parameter int                INST_IDX    = 0,
  parameter int                HOLD_CYCLES = 1,
  parameter int                STICKY      = 0,
  parameter int                EVT_W       = 8,
  localparam int               CH_W        = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_IDLE-1:0] inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  input  logic [NUM_SUB-1:0]  sub_block_sigs,
  output logic                block,
  output logic                suspect,
  output logic [CH_W-1:0]     block_chan,
  output logic [EVT_W-1:0]    event_count
);

  // Hold counter only needs to reach HOLD_CYCLES-1.
  localparam int                CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [EVT_W-1:0]  EVT_MAX   = '1;
  localparam bit                SELF_EN   = (SELF_CHECK != 0);
  localparam bit                STICKY_EN = (STICKY != 0);
  localparam bit                HOLD_ONE  = (HOLD_CYCLES <= 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SUSPECT,
    S_BLOCKED
  } state_e;

  function automatic logic [CH_W-1:0] lowest_idx(input logic [NUM_AXIS-1:0] v);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = NUM_AXIS - 1; i >= 0; i--) begin
      if (v[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
    return (v == EVT_MAX) ? v : v + EVT_W'(1);
  endfunction

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CH_W-1:0]     chan_q, chan_d;
  logic [EVT_W-1:0]    evt_q, evt_d;

  logic [NUM_AXIS-1:0] axis_owned;
  logic                axis_any;
  logic                sub_any;
  logic                self_blk;
  logic                cond;
  logic                enter_blk;
  logic                unused_inputs;

  assign axis_owned    = axis_block_sigs & AXIS_MASK;
  assign axis_any      = |axis_owned;
  assign sub_any       = |(sub_block_sigs & SUB_MASK);
  assign self_blk      = SELF_EN & inst_block_sigs[INST_IDX] & ~inst_idle_sigs[INST_IDX];
  assign cond          = axis_any & (sub_any | self_blk);
  assign unused_inputs = ^{inst_idle_sigs, inst_block_sigs};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    chan_d    = chan_q;
    evt_d     = evt_q;
    enter_blk = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cond) begin
          if (HOLD_ONE) begin
            enter_blk = 1'b1;
          end else begin
            state_d = S_SUSPECT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      S_SUSPECT: begin
        if (!cond) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          enter_blk = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BLOCKED: begin
        // A re-rising cond while still blocked does not restart the hold-off.
        if (!cond && !STICKY_EN) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (enter_blk) begin
      state_d = S_BLOCKED;
      cnt_d   = '0;
      chan_d  = lowest_idx(axis_owned);
      evt_d   = sat_inc(evt_q);
    end

    // Clear wins over everything, including an entry into BLOCKED this cycle.
    if (clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      chan_d  = '0;
      evt_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      chan_q  <= '0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chan_q  <= chan_d;
      evt_q   <= evt_d;
    end
  end

  assign block       = (state_q == S_BLOCKED);
  assign suspect     = (state_q == S_SUSPECT);
  assign block_chan  = chan_q;
  assign event_count = evt_q;

endmodule
